checkbits_seq_monitor: RTL

Synthesizable, parametrised monitor that watches a probe bus (typically mprj_io[31:16] checkbits) and checks that it steps through a programmed sequence of expected marker values.
- Successor to the fixed wait-chain used in our firmware-handshake benches.
- Adds runtime-loadable expected values with per-entry masks, a glitch filter, per-step timeout, strict/lenient modes and cycle accounting.
- Sits beside the user project in the Caravel harness, or instantiated in benches; status is readable via LA/Wishbone glue.

---
 rtl/checkbits_mon_pkg.sv | 21 ++
 rtl/checkbits_stable_filter.sv | 75 +++++++
 rtl/checkbits_seq_monitor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/checkbits_mon_pkg.sv
// ---------------------------------------------------------------------------
// checkbits_mon_pkg
//   Shared types and constants for the checkbits sequence monitor.
//   - mon_state_e : monitor FSM states
//   - FC_*        : fail_code_o encodings
// ---------------------------------------------------------------------------
package checkbits_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } mon_state_e;

    localparam logic [1:0] FC_NONE       = 2'd0;
    localparam logic [1:0] FC_TIMEOUT    = 2'd1;
    localparam logic [1:0] FC_UNEXPECTED = 2'd2;
    localparam logic [1:0] FC_BADLEN     = 2'd3;

endpackage : checkbits_mon_pkg

// File: rtl/checkbits_stable_filter.sv
// ---------------------------------------------------------------------------
// checkbits_stable_filter
//   Two-flop synchroniser followed by a run-length glitch filter.
//   A value is accepted once the synchronised bus has held it for
//   STABLE_CYCLES consecutive samples; probe change to stable_val takes
//   2 + STABLE_CYCLES clock cycles.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   data       in   raw (asynchronous) probe bus
//   stable     out  current synchronised value has met the run length
//   stable_val out  last accepted value (held between acceptances)
//   new_stable out  one-cycle pulse: a new run was accepted this cycle
// ---------------------------------------------------------------------------
module checkbits_stable_filter #(
    parameter int DATA_W        = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    output logic              stable,
    output logic [DATA_W-1:0] stable_val,
    output logic              new_stable
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] sync_q1;
    logic [DATA_W-1:0] sync_q2;
    logic [DATA_W-1:0] run_val_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic [CNT_W-1:0]  run_cnt_d;
    logic              same;
    logic              reached;

    always_comb begin
        same      = (sync_q2 == run_val_q);
        run_cnt_d = CNT_ONE;
        if (same) begin
            run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;
        end
        // A run is accepted exactly once: on the sample that brings the count
        // up to the limit. An already-saturated run of the same value does not
        // fire again, but a changed value fires immediately when the limit is 1.
        reached = (run_cnt_d == CNT_MAX) && !(same && (run_cnt_q == CNT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1    <= '0;
            sync_q2    <= '0;
            run_val_q  <= '0;
            run_cnt_q  <= '0;
            stable_val <= '0;
            new_stable <= 1'b0;
        end else begin
            sync_q1    <= data;
            sync_q2    <= sync_q1;
            run_val_q  <= sync_q2;
            run_cnt_q  <= run_cnt_d;
            new_stable <= reached;
            if (reached) begin
                stable_val <= sync_q2;
            end
        end
    end

    // While the run is saturated, run_val_q equals stable_val.
    assign stable = (run_cnt_q == CNT_MAX);

endmodule : checkbits_stable_filter

// File: rtl/checkbits_seq_monitor.sv
// ---------------------------------------------------------------------------
// checkbits_seq_monitor
//   Watches a probe bus and checks that it walks through a programmed table
//   of (expected value, compare mask) entries in order.
//
// Ports:
//   wb_clk_i       in   clock
//   wb_rst_i       in   asynchronous active-high reset
//   probe_i        in   monitored bus (asynchronous)
//   cfg_we_i       in   table write strobe (ignored while busy)
//   cfg_addr_i     in   table index
//   cfg_exp_i      in   expected value
//   cfg_mask_i     in   compare mask, 1 = bit compared
//   seq_len_i      in   number of table entries in use (sampled on start)
//   timeout_i      in   per-step cycle limit, 0 disables
//   strict_i       in   1 = unexpected stable values fail the check
//   start_i        in   begin a check (ignored while busy)
//   abort_i        in   return to idle from any state
//   busy_o         out  check in progress
//   pass_o         out  sticky pass
//   fail_o         out  sticky fail
//   fail_code_o    out  0 none, 1 timeout, 2 unexpected, 3 bad length
//   step_idx_o     out  index of the entry being awaited
//   step_pulse_o   out  one-cycle pulse per matched entry
//   step_cycles_o  out  cycles the last matched step took
//   fail_value_o   out  stable probe value captured on entry to FAIL
//
// Handshake: start_i and abort_i are level-sampled single-cycle pulses; no
// ready is returned. abort_i wins over everything, and start_i only acts when
// the monitor is not busy. step_pulse_o is valid for exactly one cycle.
// ---------------------------------------------------------------------------
module checkbits_seq_monitor
    import checkbits_mon_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_W     = 24,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [DATA_W-1:0]          probe_i,
    input  logic                       cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
    input  logic [DATA_W-1:0]          cfg_exp_i,
    input  logic [DATA_W-1:0]          cfg_mask_i,
    input  logic [$clog2(DEPTH):0]     seq_len_i,
    input  logic [TIMEOUT_W-1:0]       timeout_i,
    input  logic                       strict_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic [1:0]                 fail_code_o,
    output logic [$clog2(DEPTH):0]     step_idx_o,
    output logic                       step_pulse_o,
    output logic [TIMEOUT_W-1:0]       step_cycles_o,
    output logic [DATA_W-1:0]          fail_value_o
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             IW      = AW + 1;
    localparam logic [IW-1:0]  IDX_ONE = IW'(1);
    localparam logic [IW-1:0]  MAX_LEN = IW'(DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic              stable;
    logic [DATA_W-1:0] stable_val;
    logic              new_stable;

    checkbits_stable_filter #(
        .DATA_W        (DATA_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .data       (probe_i),
        .stable     (stable),
        .stable_val (stable_val),
        .new_stable (new_stable)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    mon_state_e           state_q;
    mon_state_e           state_d;
    logic [IW-1:0]        step_idx_q;
    logic [IW-1:0]        seq_len_q;
    logic [TIMEOUT_W-1:0] timer_q;
    logic [1:0]           fail_code_q;
    logic                 step_pulse_q;
    logic [TIMEOUT_W-1:0] step_cycles_q;
    logic [DATA_W-1:0]    fail_value_q;
    logic [DATA_W-1:0]    last_val_q;
    logic                 last_valid_q;

    // ------------------------------------------------------------------
    // Sequence table (not reset; written only while not busy)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] exp_mem  [DEPTH];
    logic [DATA_W-1:0] mask_mem [DEPTH];

    always_ff @(posedge wb_clk_i) begin
        if (cfg_we_i && (state_q != ST_WAIT)) begin
            exp_mem[cfg_addr_i]  <= cfg_exp_i;
            mask_mem[cfg_addr_i] <= cfg_mask_i;
        end
    end

    // ------------------------------------------------------------------
    // Compare logic
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] exp_cur;
    logic [DATA_W-1:0] mask_cur;
    logic              hit;
    logic              seen_last;
    logic              len_bad;
    logic              timer_hit;
    logic              unexpected;
    logic              last_step;

    always_comb begin
        // While busy, step_idx_q < seq_len_q <= DEPTH, so the low bits
        // address the table directly.
        exp_cur    = exp_mem[step_idx_q[AW-1:0]];
        mask_cur   = mask_mem[step_idx_q[AW-1:0]];
        hit        = stable && (((stable_val ^ exp_cur) & mask_cur) == '0);
        seen_last  = last_valid_q && (stable_val == last_val_q);
        len_bad    = (seq_len_i == '0) || (seq_len_i > MAX_LEN);
        timer_hit  = (timeout_i != '0) && (timer_q == timeout_i);
        // The value we just matched is still on the bus for a while, and in
        // strict mode re-settling on it (after a glitch) is not a violation.
        unexpected = strict_i && new_stable && !seen_last;
        last_step  = (step_idx_q == (seq_len_q - IDX_ONE));
    end

    // ------------------------------------------------------------------
    // FSM next-state and event decode
    // ------------------------------------------------------------------
    logic ev_abort;
    logic ev_start;
    logic ev_badlen;
    logic ev_match;
    logic ev_timeout;
    logic ev_unexp;

    always_comb begin
        state_d    = state_q;
        ev_abort   = 1'b0;
        ev_start   = 1'b0;
        ev_badlen  = 1'b0;
        ev_match   = 1'b0;
        ev_timeout = 1'b0;
        ev_unexp   = 1'b0;

        if (abort_i) begin
            state_d  = ST_IDLE;
            ev_abort = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start_i) begin
                        if (len_bad) begin
                            state_d   = ST_FAIL;
                            ev_badlen = 1'b1;
                        end else begin
                            state_d  = ST_WAIT;
                            ev_start = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (hit) begin
                        ev_match = 1'b1;
                        if (last_step) begin
                            state_d = ST_PASS;
                        end
                    end else if (timer_hit) begin
                        state_d    = ST_FAIL;
                        ev_timeout = 1'b1;
                    end else if (unexpected) begin
                        state_d  = ST_FAIL;
                        ev_unexp = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            step_idx_q    <= '0;
            seq_len_q     <= '0;
            timer_q       <= '0;
            fail_code_q   <= FC_NONE;
            step_pulse_q  <= 1'b0;
            step_cycles_q <= '0;
            fail_value_q  <= '0;
            last_val_q    <= '0;
            last_valid_q  <= 1'b0;
        end else begin
            step_pulse_q <= ev_match;

            if (ev_abort) begin
                step_idx_q  <= '0;
                fail_code_q <= FC_NONE;
            end else if (ev_badlen) begin
                fail_code_q  <= FC_BADLEN;
                fail_value_q <= stable_val;
            end else if (ev_start) begin
                step_idx_q   <= '0;
                seq_len_q    <= seq_len_i;
                timer_q      <= '0;
                fail_code_q  <= FC_NONE;
                last_valid_q <= 1'b0;
            end else if (ev_match) begin
                step_cycles_q <= timer_q;
                timer_q       <= '0;
                step_idx_q    <= step_idx_q + IDX_ONE;
                last_val_q    <= stable_val;
                last_valid_q  <= 1'b1;
            end else if (ev_timeout) begin
                fail_code_q  <= FC_TIMEOUT;
                fail_value_q <= stable_val;
            end else if (ev_unexp) begin
                fail_code_q  <= FC_UNEXPECTED;
                fail_value_q <= stable_val;
            end else if (state_q == ST_WAIT) begin
                if (timer_q != '1) begin
                    timer_q <= timer_q + TIMEOUT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_o        = (state_q == ST_WAIT);
    assign pass_o        = (state_q == ST_PASS);
    assign fail_o        = (state_q == ST_FAIL);
    assign fail_code_o   = fail_code_q;
    assign step_idx_o    = step_idx_q;
    assign step_pulse_o  = step_pulse_q;
    assign step_cycles_o = step_cycles_q;
    assign fail_value_o  = fail_value_q;

endmodule : checkbits_seq_monitor
